// File: rtl/div_pkg.sv
// Shared definitions for the divide sequencer slice.
//   W          : operand/result width, matches the sequential Divider
//   DIV_CYCLES : Divider run cycles per operation (S counts 0..DIV_CYCLES-1)
//   DZ_QUOT    : quotient reported for a divide by zero (all ones)
//   state_t    : sequencer FSM states
package div_pkg;

    localparam int W          = 32;
    localparam int DIV_CYCLES = 34;

    localparam logic [W-1:0] DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_fixup.sv
// Result fix-up between the Divider outputs and the response registers.
// The Divider only sees a non-negative divisor magnitude and floors the
// quotient, so a negative signed divisor is handled by negating the quotient
// here. A zero divisor bypasses the Divider entirely.
//   negq     : divisor was negative in a signed op -> negate quotient
//   dz       : divisor was zero -> quot = all ones, rem = dividend
//   x        : dividend (only used for the divide-by-zero remainder)
//   div_quot : raw Divider quotient
//   div_rem  : raw Divider remainder
//   quot/rem : fixed-up result
//   dz_out   : divide-by-zero flag for the response
module div_fixup #(
    parameter int W = div_pkg::W
) (
    input  logic         negq,
    input  logic         dz,
    input  logic [W-1:0] x,
    input  logic [W-1:0] div_quot,
    input  logic [W-1:0] div_rem,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         dz_out
);
    import div_pkg::*;

    logic [W-1:0] quot_signed;

    // Euclidean fix-up: x = q*y + r with 0 <= r < |y| when y < 0 means
    // q = -floor(x/|y|) and the remainder is unchanged.
    assign quot_signed = negq ? (-div_quot) : div_quot;

    assign quot   = dz ? DZ_QUOT : quot_signed;
    assign rem    = dz ? x : div_rem;
    assign dz_out = dz;

endmodule

// File: rtl/div_sequencer.sv
// Request/response front-end for the 32-bit sequential Divider.
// Accepts one operation per req handshake, runs the Divider with a
// non-negative divisor magnitude, captures the result when stall drops,
// applies sign / divide-by-zero fix-ups and holds the response until taken.
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake
//   req_signed, req_x, req_y    : operation, dividend, divisor
//   resp_valid/resp_ready       : response handshake
//   resp_quot, resp_rem, resp_dz: result, held stable while resp_valid=1
//   div_run, div_u, div_x, div_y: to the Divider (div_y is |y|)
//   div_stall, div_quot, div_rem: from the Divider
module div_sequencer #(
    parameter int W          = div_pkg::W,
    parameter int DIV_CYCLES = div_pkg::DIV_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_signed,
    input  logic [W-1:0] req_x,
    input  logic [W-1:0] req_y,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_quot,
    output logic [W-1:0] resp_rem,
    output logic         resp_dz,
    output logic         div_run,
    output logic         div_u,
    output logic [W-1:0] div_x,
    output logic [W-1:0] div_y,
    input  logic         div_stall,
    input  logic [W-1:0] div_quot,
    input  logic [W-1:0] div_rem
);
    import div_pkg::*;

    localparam int                CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(DIV_CYCLES - 1);

    state_t state_reg, state_next;

    logic [W-1:0] x_reg;
    logic [W-1:0] ymag_reg;
    logic         signed_reg;
    logic         negq_reg;
    logic [W-1:0] quot_reg;
    logic [W-1:0] rem_reg;
    logic         dz_reg;
    logic [CNT_W-1:0] run_cnt_reg;

    logic         op_load;
    logic         res_load;

    // Request decode, used only when an operation is accepted in IDLE.
    logic         req_dz;
    logic         req_negq;
    logic [W-1:0] req_ymag;

    assign req_dz   = (req_y == '0);
    assign req_negq = req_signed & req_y[W-1];
    // 0x80000000 negates to itself, which the Divider reads as unsigned 2^31.
    assign req_ymag = req_negq ? (-req_y) : req_y;

    // Fix-up inputs: the divide-by-zero path completes straight from IDLE
    // using the live request; the normal path completes from RUN.
    logic         fix_dz_in;
    logic [W-1:0] fix_quot;
    logic [W-1:0] fix_rem;
    logic         fix_dz;

    assign fix_dz_in = (state_reg == IDLE) & req_dz;

    div_fixup #(
        .W (W)
    ) u_fixup (
        .negq     (negq_reg),
        .dz       (fix_dz_in),
        .x        (req_x),
        .div_quot (div_quot),
        .div_rem  (div_rem),
        .quot     (fix_quot),
        .rem      (fix_rem),
        .dz_out   (fix_dz)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_load    = 1'b0;
        res_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_load = 1'b1;
                    if (req_dz) begin
                        res_load   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (!div_stall) begin
                    res_load   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            ymag_reg   <= '0;
            signed_reg <= 1'b0;
            negq_reg   <= 1'b0;
            quot_reg   <= '0;
            rem_reg    <= '0;
            dz_reg     <= 1'b0;
        end else begin
            if (op_load) begin
                x_reg      <= req_x;
                ymag_reg   <= req_ymag;
                signed_reg <= req_signed;
                negq_reg   <= req_negq;
            end
            if (res_load) begin
                quot_reg <= fix_quot;
                rem_reg  <= fix_rem;
                dz_reg   <= fix_dz;
            end
        end
    end

    // Counts cycles spent in RUN; only observed by the checks below.
    always_ff @(posedge clk) begin
        if (rst || state_reg != RUN) begin
            run_cnt_reg <= '0;
        end else begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
        end
    end

    // Outputs. div_run is low in DONE, so the Divider's S returns to 0
    // before the next operation starts.
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == DONE);
    assign div_run    = (state_reg == RUN);
    assign div_u      = signed_reg;
    assign div_x      = x_reg;
    assign div_y      = ymag_reg;
    assign resp_quot  = quot_reg;
    assign resp_rem   = rem_reg;
    assign resp_dz    = dz_reg;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(div_run && state_reg != RUN));
            assert (!(state_reg == RUN && run_cnt_reg > RUN_LAST));
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer. Contains a behavioural Divider
// (floor division, result valid on its last run cycle, junk otherwise) and a
// Euclidean-division reference model checked every cycle at the negedge.
module tb_div_sequencer;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_quot;
    logic [31:0] resp_rem;
    logic        resp_dz;
    logic        div_run;
    logic        div_u;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_stall;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    div_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_quot  (resp_quot),
        .resp_rem   (resp_rem),
        .resp_dz    (resp_dz),
        .div_run    (div_run),
        .div_u      (div_u),
        .div_x      (div_x),
        .div_y      (div_y),
        .div_stall  (div_stall),
        .div_quot   (div_quot),
        .div_rem    (div_rem)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, got no event, required one (cycle %0d)", name, cycle);
    endtask

    // ---------------- Behavioural Divider ----------------
    function automatic void floor_div(input bit u, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] q, output logic [31:0] r);
        longint xs, ys, lq, lr;
        xs = u ? longint'($signed(x)) : longint'({32'h0, x});
        ys = longint'({32'h0, y});
        if (ys == 0) begin
            q = '0;
            r = '0;
        end else begin
            lq = xs / ys;
            lr = xs - lq * ys;
            if (lr < 0) begin
                lq = lq - 1;
                lr = lr + ys;
            end
            q = lq[31:0];
            r = lr[31:0];
        end
    endfunction

    int unsigned s_cnt = 0;
    logic [31:0] junk_q = '0;
    logic [31:0] junk_r = '0;
    logic [31:0] fq, fr;

    always @(posedge clk) begin
        if (!div_run) s_cnt <= 0;
        else          s_cnt <= s_cnt + 1;
        junk_q <= $urandom;
        junk_r <= $urandom;
    end

    always_comb begin
        fq = '0;
        fr = '0;
        floor_div(div_u, div_x, div_y, fq, fr);
    end

    assign div_stall = div_run && (s_cnt != DIV_CYCLES - 1);
    assign div_quot  = (div_run && s_cnt == DIV_CYCLES - 1) ? fq : junk_q;
    assign div_rem   = (div_run && s_cnt == DIV_CYCLES - 1) ? fr : junk_r;

    // ---------------- Reference model ----------------
    function automatic void euclid(input bit sg, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] q, output logic [31:0] r, output bit dz);
        longint xs, ys, lq, lr;
        if (y == 32'h0) begin
            q  = 32'hFFFF_FFFF;
            r  = x;
            dz = 1'b1;
        end else begin
            xs = sg ? longint'($signed(x)) : longint'({32'h0, x});
            ys = sg ? longint'($signed(y)) : longint'({32'h0, y});
            lq = xs / ys;
            lr = xs - lq * ys;
            if (lr < 0) begin
                if (ys > 0) begin lq = lq - 1; lr = lr + ys; end
                else        begin lq = lq + 1; lr = lr - ys; end
            end
            q  = lq[31:0];
            r  = lr[31:0];
            dz = 1'b0;
        end
    endfunction

    // Checks outputs for the cycle just begun, then advances the model with
    // the inputs the DUT will see at the next rising edge.
    initial begin
        bit          chk_en;
        bit          m_pending;
        int          m_done_from;
        logic [31:0] m_q, m_r, m_x, m_ymag;
        bit          m_dz, m_sg, done, running;
        chk_en      = 0;
        m_pending   = 0;
        m_done_from = 0;
        m_q = '0; m_r = '0; m_x = '0; m_ymag = '0; m_dz = 0; m_sg = 0;
        forever begin
            @(negedge clk);
            done    = m_pending && (cycle >= m_done_from);
            running = m_pending && !done;
            if (chk_en) begin
                chk("req_ready",  {31'h0, req_ready},  {31'h0, !m_pending});
                chk("resp_valid", {31'h0, resp_valid}, {31'h0, done});
                chk("div_run",    {31'h0, div_run},    {31'h0, running});
                if (done) begin
                    chk("resp_quot", resp_quot, m_q);
                    chk("resp_rem",  resp_rem,  m_r);
                    chk("resp_dz",   {31'h0, resp_dz}, {31'h0, m_dz});
                end
                if (running) begin
                    chk("div_u", {31'h0, div_u}, {31'h0, m_sg});
                    chk("div_x", div_x, m_x);
                    chk("div_y", div_y, m_ymag);
                end
            end
            if (rst) begin
                m_pending = 0;
                chk_en    = 1;
            end else if (chk_en) begin
                if (!m_pending && req_valid) begin
                    euclid(req_signed, req_x, req_y, m_q, m_r, m_dz);
                    m_sg        = req_signed;
                    m_x         = req_x;
                    m_ymag      = (req_signed && req_y[31]) ? (32'h0 - req_y) : req_y;
                    m_pending   = 1;
                    m_done_from = cycle + 1 + (m_dz ? 0 : DIV_CYCLES);
                end else if (done && resp_ready) begin
                    m_pending = 0;
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    // Runs one operation. With lit=1 the result, latency and run length are
    // also checked against hand-computed values.
    task automatic do_op(input bit sg, input logic [31:0] x, input logic [31:0] y,
                         input bit lit, input logic [31:0] eq, input logic [31:0] er,
                         input bit edz, input int hold);
        int t, acc, runs;
        t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk); #2; t++;
        end
        if (!req_ready) begin
            timeout_fail("wait_req_ready");
            return;
        end
        req_signed = sg;
        req_x      = x;
        req_y      = y;
        req_valid  = 1'b1;
        @(posedge clk); #2;
        acc       = cycle;
        req_valid = 1'b0;
        req_x     = $urandom;
        req_y     = $urandom;
        runs = 0;
        t    = 0;
        while (!resp_valid && t < 100) begin
            if (div_run) runs++;
            @(posedge clk); #2; t++;
        end
        if (!resp_valid) begin
            timeout_fail("wait_resp_valid");
            return;
        end
        if (lit) begin
            chk("lit_latency", 32'(cycle - acc), edz ? 32'd0 : 32'(DIV_CYCLES));
            chk("lit_run_cycles", 32'(runs), edz ? 32'd0 : 32'(DIV_CYCLES));
            chk("lit_quot", resp_quot, eq);
            chk("lit_rem",  resp_rem,  er);
            chk("lit_dz",   {31'h0, resp_dz}, {31'h0, edz});
        end
        $display("op sg=%0d x=0x%08h y=0x%08h -> q=0x%08h r=0x%08h dz=%0d",
                 sg, x, y, resp_quot, resp_rem, resp_dz);
        // Backpressure: a competing request must not be taken meanwhile.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #2;
            if (lit) begin
                chk("hold_valid", {31'h0, resp_valid}, 32'h1);
                chk("hold_ready", {31'h0, req_ready},  32'h0);
                chk("hold_quot",  resp_quot, eq);
                chk("hold_rem",   resp_rem,  er);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #2;
        resp_ready = 1'b0;
    endtask

    task automatic reset_mid_run();
        int t;
        req_signed = 1'b0;
        req_x      = 32'd12345;
        req_y      = 32'd67;
        req_valid  = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        repeat (16) begin @(posedge clk); #2; end
        chk("pre_rst_run", {31'h0, div_run}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rst_run_low",   {31'h0, div_run},    32'h0);
        chk("rst_no_resp",   {31'h0, resp_valid}, 32'h0);
        chk("rst_idle",      {31'h0, req_ready},  32'h1);
        $display("reset during RUN: run=%0d valid=%0d ready=%0d", div_run, resp_valid, req_ready);
        t = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (resp_valid) t++;
        end
        chk("rst_no_late_resp", 32'(t), 32'h0);
    endtask

    initial begin
        logic [31:0] rx, ry;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset_req_ready",  {31'h0, req_ready},  32'h1);
        chk("reset_div_run",    {31'h0, div_run},    32'h0);
        chk("reset_quot",       resp_quot, 32'h0);
        chk("reset_rem",        resp_rem,  32'h0);
        chk("reset_dz",         {31'h0, resp_dz}, 32'h0);
        chk("reset_div_x",      div_x, 32'h0);
        chk("reset_div_y",      div_y, 32'h0);

        do_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFC, 32'd1, 1'b0, 0);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
        do_op(1'b1, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        do_op(1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        do_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 10);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0FFF_FFFF, 32'hF, 1'b0, 0);

        reset_mid_run();
        do_op(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0, 0);

        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 0);
        do_op(1'b1, 32'h8000_0000, 32'd3, 1'b1, 32'hD555_5555, 32'd1, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       ry = 32'h0;
                1:       ry = $urandom_range(1, 15);
                2:       ry = 32'h8000_0000;
                3:       ry = 32'hFFFF_FFFF;
                4:       ry = 32'h0 - 32'($urandom_range(1, 15));
                default: ry = $urandom;
            endcase
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            do_op(1'($urandom_range(0, 1)), rx, ry, 1'b0, 32'h0, 32'h0, 1'b0,
                  int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
